decode_stage: RTL and testbench

- Second pipeline stage of the 16-bit CPU, directly downstream of fetch.
- Consumes the fetch-register outputs: the instruction and next PC.
- Holds the 8x16 register file and extracts instruction fields and the immediate.
- Detects load-use hazards and registers everything into the decode/execute pipeline register, which supports stall, flush and bubble insertion.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/decode_regfile.sv | 57 +++++
 rtl/decode_stage.sv | 97 +++++++++
 tb/tb_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, decode/execute register layout and immediate helper
package cpu_pkg;

   localparam int DW    = 16;
   localparam int NREG  = 8;
   localparam int REG_W = $clog2(NREG);

   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 11;
   localparam int RS_MSB  = 10;
   localparam int RS_LSB  = 8;
   localparam int RT_MSB  = 7;
   localparam int RT_LSB  = 5;
   localparam int RD_MSB  = 4;
   localparam int RD_LSB  = 2;

   localparam logic [1:0] IMM_S5  = 2'b00;
   localparam logic [1:0] IMM_S8  = 2'b01;
   localparam logic [1:0] IMM_Z8  = 2'b10;
   localparam logic [1:0] IMM_S11 = 2'b11;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [DW-1:0]              nextPc;
      logic [DW-1:0]              rsData;
      logic [DW-1:0]              rtData;
      logic [DW-1:0]              imm;
      logic [OPC_MSB-OPC_LSB:0]   opcode;
      logic [REG_W-1:0]           rs;
      logic [REG_W-1:0]           rt;
      logic [REG_W-1:0]           rd;
      logic                       valid;
   } dxReg_t;

   // The all-zero record doubles as the bubble, so downstream only needs to check valid.
   localparam dxReg_t DX_BUBBLE = '0;

   function automatic logic [DW-1:0] genImm(input logic [DW-1:0] instr, input logic [1:0] sel);
      logic [DW-1:0] imm;
      case (sel)
         IMM_S5:  imm = {{(DW-5){instr[4]}}, instr[4:0]};
         IMM_S8:  imm = {{(DW-8){instr[7]}}, instr[7:0]};
         IMM_Z8:  imm = {{(DW-8){1'b0}}, instr[7:0]};
         default: imm = {{(DW-11){instr[10]}}, instr[10:0]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - 2-read/1-write register file, R0 hardwired to zero
// Optional write-through bypass when DECODE_WB_BYPASS_EN is defined.
module decode_regfile #(
   parameter  int NREG = 8,
   parameter  int DW   = 16,
   localparam int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] rdRegA,
   input  logic [RW-1:0] rdRegB,
   output logic [DW-1:0] rdDataA,
   output logic [DW-1:0] rdDataB,
   input  logic          wrEn,
   input  logic [RW-1:0] wrReg,
   input  logic [DW-1:0] wrData
);
   import cpu_pkg::*;

   logic [DW-1:0] regs [NREG];
   logic          wrLive;
   logic          bypA;
   logic          bypB;

   assign wrLive = wrEn && (wrReg != REG_ZERO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (wrLive) begin
         regs[wrReg] <= wrData;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   assign bypA = wrLive && (wrReg == rdRegA);
   assign bypB = wrLive && (wrReg == rdRegB);
`else
   assign bypA = 1'b0;
   assign bypB = 1'b0;
`endif

   // R0 is forced here rather than relying on regs[0] staying clear.
   always_comb begin
      rdDataA = '0;
      rdDataB = '0;
      if (rdRegA != REG_ZERO) begin
         rdDataA = bypA ? wrData : regs[rdRegA];
      end
      if (rdRegB != REG_ZERO) begin
         rdDataB = bypB ? wrData : regs[rdRegB];
      end
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: field extraction, load-use detect, decode/execute register
// Register-file write-through is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage #(
   parameter  int NREG = 8,
   parameter  int DW   = 16,
   localparam int RW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] Instruct,
   input  logic [DW-1:0] NextPCIn,
   input  logic          InValid,
   input  logic          Stall,
   input  logic          Flush,
   input  logic [1:0]    ImmSel,
   input  logic          WrEn,
   input  logic [RW-1:0] WrReg,
   input  logic [DW-1:0] WrData,
   input  logic          ExMemRead,
   input  logic [RW-1:0] ExDestReg,
   output logic          LoadUseStall,
   output logic [DW-1:0] NextPCOut,
   output logic [DW-1:0] RsData,
   output logic [DW-1:0] RtData,
   output logic [DW-1:0] Imm,
   output logic [4:0]    Opcode,
   output logic [RW-1:0] Rs,
   output logic [RW-1:0] Rt,
   output logic [RW-1:0] Rd,
   output logic          Valid
);
   import cpu_pkg::*;

   logic [RW-1:0] decRs;
   logic [RW-1:0] decRt;
   logic [DW-1:0] rfRsData;
   logic [DW-1:0] rfRtData;
   dxReg_t        dxD;
   dxReg_t        dxQ;

   assign decRs = Instruct[RS_MSB:RS_LSB];
   assign decRt = Instruct[RT_MSB:RT_LSB];

   decode_regfile #(
      .NREG (NREG),
      .DW   (DW)
   ) uRegfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .rdRegA  (decRs),
      .rdRegB  (decRt),
      .rdDataA (rfRsData),
      .rdDataB (rfRtData),
      .wrEn    (WrEn),
      .wrReg   (WrReg),
      .wrData  (WrData)
   );

   // Conservative: any Rs/Rt match stalls, whether or not the opcode reads that field.
   assign LoadUseStall = InValid && ExMemRead && (ExDestReg != REG_ZERO) &&
                         ((ExDestReg == decRs) || (ExDestReg == decRt));

   always_comb begin
      dxD        = DX_BUBBLE;
      dxD.nextPc = NextPCIn;
      dxD.rsData = rfRsData;
      dxD.rtData = rfRtData;
      dxD.imm    = genImm(Instruct, ImmSel);
      dxD.opcode = Instruct[OPC_MSB:OPC_LSB];
      dxD.rs     = decRs;
      dxD.rt     = decRt;
      dxD.rd     = Instruct[RD_MSB:RD_LSB];
      dxD.valid  = InValid;
   end

   // Flush beats Stall; a load-use bubble only goes in when the pipe is moving.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dxQ <= DX_BUBBLE;
      end else if (Flush) begin
         dxQ <= DX_BUBBLE;
      end else if (!Stall) begin
         dxQ <= LoadUseStall ? DX_BUBBLE : dxD;
      end
   end

   assign NextPCOut = dxQ.nextPc;
   assign RsData    = dxQ.rsData;
   assign RtData    = dxQ.rtData;
   assign Imm       = dxQ.imm;
   assign Opcode    = dxQ.opcode;
   assign Rs        = dxQ.rs;
   assign Rt        = dxQ.rt;
   assign Rd        = dxQ.rd;
   assign Valid     = dxQ.valid;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a behavioural model
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] Instruct = '0;
   logic [15:0] NextPCIn = '0;
   logic        InValid = 1'b0;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic [1:0]  ImmSel = '0;
   logic        WrEn = 1'b0;
   logic [2:0]  WrReg = '0;
   logic [15:0] WrData = '0;
   logic        ExMemRead = 1'b0;
   logic [2:0]  ExDestReg = '0;

   logic        LoadUseStall;
   logic [15:0] NextPCOut;
   logic [15:0] RsData;
   logic [15:0] RtData;
   logic [15:0] Imm;
   logic [4:0]  Opcode;
   logic [2:0]  Rs;
   logic [2:0]  Rt;
   logic [2:0]  Rd;
   logic        Valid;

   int nCmp = 0;
   int nBad = 0;

`ifdef DECODE_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   decode_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Instruct     (Instruct),
      .NextPCIn     (NextPCIn),
      .InValid      (InValid),
      .Stall        (Stall),
      .Flush        (Flush),
      .ImmSel       (ImmSel),
      .WrEn         (WrEn),
      .WrReg        (WrReg),
      .WrData       (WrData),
      .ExMemRead    (ExMemRead),
      .ExDestReg    (ExDestReg),
      .LoadUseStall (LoadUseStall),
      .NextPCOut    (NextPCOut),
      .RsData       (RsData),
      .RtData       (RtData),
      .Imm          (Imm),
      .Opcode       (Opcode),
      .Rs           (Rs),
      .Rt           (Rt),
      .Rd           (Rd),
      .Valid        (Valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int pc, rsd, rtd, imm, opc, rs, rt, rd, v;
   } mout_t;

   mout_t mOut = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   int    mReg [8];

   function automatic int fieldOf(input logic [15:0] ins, input int shift, input int bits);
      return (int'(ins) >> shift) % (1 << bits);
   endfunction

   function automatic int mImm(input logic [15:0] ins, input logic [1:0] sel);
      int v;
      case (sel)
         2'd0: begin v = int'(ins) % 32;   if (v >= 16)   v -= 32;   end
         2'd1: begin v = int'(ins) % 256;  if (v >= 128)  v -= 256;  end
         2'd2: v = int'(ins) % 256;
         default: begin v = int'(ins) % 2048; if (v >= 1024) v -= 2048; end
      endcase
      return v & 16'hFFFF;
   endfunction

   function automatic int mRead(input int idx);
      if (idx == 0) return 0;
      if (BYP && WrEn && int'(WrReg) == idx) return int'(WrData);
      return mReg[idx];
   endfunction

   function automatic int mStall();
      int rs = fieldOf(Instruct, 8, 3);
      int rt = fieldOf(Instruct, 5, 3);
      int d  = int'(ExDestReg);
      return (InValid && ExMemRead && d != 0 && (d == rs || d == rt)) ? 1 : 0;
   endfunction

   function automatic mout_t bubble();
      mout_t b = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      return b;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mOut = bubble();
         for (int i = 0; i < 8; i++) mReg[i] = 0;
      end else begin
         if (Flush) begin
            mOut = bubble();
         end else if (Stall) begin
            mOut = mOut;
         end else if (mStall() != 0) begin
            mOut = bubble();
         end else begin
            mOut.pc  = int'(NextPCIn);
            mOut.rs  = fieldOf(Instruct, 8, 3);
            mOut.rt  = fieldOf(Instruct, 5, 3);
            mOut.rd  = fieldOf(Instruct, 2, 3);
            mOut.opc = fieldOf(Instruct, 11, 5);
            mOut.rsd = mRead(mOut.rs);
            mOut.rtd = mRead(mOut.rt);
            mOut.imm = mImm(Instruct, ImmSel);
            mOut.v   = InValid ? 1 : 0;
         end
         if (WrEn && WrReg != 3'd0) mReg[WrReg] = int'(WrData);
      end
   end

   always @(negedge clk) begin
      chk("Valid",        16'(Valid),        16'(mOut.v));
      chk("NextPCOut",    NextPCOut,         16'(mOut.pc));
      chk("RsData",       RsData,            16'(mOut.rsd));
      chk("RtData",       RtData,            16'(mOut.rtd));
      chk("Imm",          Imm,               16'(mOut.imm));
      chk("Opcode",       16'(Opcode),       16'(mOut.opc));
      chk("Rs",           16'(Rs),           16'(mOut.rs));
      chk("Rt",           16'(Rt),           16'(mOut.rt));
      chk("Rd",           16'(Rd),           16'(mOut.rd));
      chk("LoadUseStall", 16'(LoadUseStall), 16'(mStall()));
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [15:0] mk(input int op, input int rs, input int rt, input int low5);
      return 16'((op << 11) | (rs << 8) | (rt << 5) | low5);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_Valid",  16'(Valid), 16'h0000);
      chk("rst_RsData", RsData,     16'h0000);
      rst_n = 1'b1;

      WrEn = 1'b1; WrReg = 3'd3; WrData = 16'h1234;
      tick();
      WrEn = 1'b0; Instruct = mk(1, 3, 0, 0); InValid = 1'b1; NextPCIn = 16'h0010;
      tick();
      chk("r3_RsData",    RsData,      16'h1234);
      chk("r3_Valid",     16'(Valid),  16'h0001);
      chk("r3_NextPCOut", NextPCOut,   16'h0010);

      ImmSel = 2'd0; Instruct = mk(2, 0, 0, 5'b10000); NextPCIn = 16'h0011;
      tick();
      chk("imm_s5", Imm, 16'hFFF0);
      ImmSel = 2'd2; Instruct = 16'h0080;
      tick();
      chk("imm_z8", Imm, 16'h0080);
      ImmSel = 2'd1;
      tick();
      chk("imm_s8", Imm, 16'hFF80);
      ImmSel = 2'd3; Instruct = 16'h0400;
      tick();
      chk("imm_s11", Imm, 16'hFC00);
      Instruct = 16'h03FF;
      tick();
      chk("imm_s11_pos", Imm, 16'h03FF);

      ImmSel = 2'd0; ExMemRead = 1'b1; ExDestReg = 3'd2; Instruct = mk(4, 1, 2, 0);
      #1 chk("lu_rt_stall", 16'(LoadUseStall), 16'h0001);
      tick();
      chk("lu_bubble", 16'(Valid), 16'h0000);
      ExDestReg = 3'd0; Instruct = mk(4, 0, 0, 0);
      #1 chk("lu_r0_nostall", 16'(LoadUseStall), 16'h0000);
      tick();
      chk("lu_r0_valid",  16'(Valid),  16'h0001);
      chk("lu_r0_opcode", 16'(Opcode), 16'h0004);
      ExDestReg = 3'd1; Instruct = mk(4, 1, 2, 0);
      #1 chk("lu_rs_stall", 16'(LoadUseStall), 16'h0001);
      InValid = 1'b0;
      #1 chk("lu_invalid_nostall", 16'(LoadUseStall), 16'h0000);
      ExMemRead = 1'b0; InValid = 1'b1;

      Instruct = mk(6, 3, 0, 0); NextPCIn = 16'h0020;
      tick();
      Flush = 1'b1; Stall = 1'b1;
      tick();
      chk("flush_over_stall_Valid",  16'(Valid),  16'h0000);
      chk("flush_over_stall_Opcode", 16'(Opcode), 16'h0000);
      Flush = 1'b0; Stall = 1'b0;
      Instruct = mk(7, 3, 3, 5'b01100); NextPCIn = 16'h0030;
      tick();
      chk("pre_stall_RsData", RsData, 16'h1234);
      chk("pre_stall_Imm",    Imm,    16'h000C);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         Instruct = mk(9 + i, 3, 1, 5'b00011); NextPCIn = 16'(16'h0031 + i);
         ExMemRead = (i == 1); ExDestReg = 3'd3;
         tick();
         chk("stall_hold_Opcode", 16'(Opcode), 16'h0007);
         chk("stall_hold_PC",     NextPCOut,   16'h0030);
         chk("stall_hold_Valid",  16'(Valid),  16'h0001);
      end
      Stall = 1'b0; ExMemRead = 1'b0;

      WrEn = 1'b1; WrReg = 3'd0; WrData = 16'hFFFF; Instruct = mk(1, 0, 0, 0);
      tick();
      WrEn = 1'b0;
      tick();
      chk("r0_read", RsData, 16'h0000);

      WrEn = 1'b1; WrReg = 3'd5; WrData = 16'h1111;
      tick();
      WrData = 16'hBEEF; Instruct = mk(1, 5, 5, 0);
      tick();
      chk("bypass_RsData", RsData, BYP ? 16'hBEEF : 16'h1111);
      chk("bypass_RtData", RtData, BYP ? 16'hBEEF : 16'h1111);
      WrEn = 1'b0;
      tick();
      chk("after_write_RsData", RsData, 16'hBEEF);

      for (int i = 0; i < 24; i++) begin
         Instruct  = 16'(i * 16'h1357 + 16'h00A5);
         NextPCIn  = 16'(16'h0100 + i);
         ImmSel    = 2'(i % 4);
         WrEn      = (i % 3 == 0);
         WrReg     = 3'(i % 8);
         WrData    = 16'(i * 16'h0111);
         ExMemRead = (i % 5 == 0);
         ExDestReg = 3'((i + 2) % 8);
         Flush     = (i % 7 == 6);
         Stall     = (i % 6 == 5);
         InValid   = (i % 4 != 3);
         tick();
      end
      Flush = 1'b0; Stall = 1'b0; ExMemRead = 1'b0; InValid = 1'b1; ImmSel = 2'd0;

      Instruct = mk(3, 3, 5, 0); WrEn = 1'b1; WrReg = 3'd3; WrData = 16'hAAAA;
      tick();
      WrReg = 3'd4; WrData = 16'h5555;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_Valid",     16'(Valid), 16'h0000);
      chk("midrst_NextPCOut", NextPCOut,  16'h0000);
      chk("midrst_RsData",    RsData,     16'h0000);
      tick();
      rst_n = 1'b1; WrEn = 1'b0; Instruct = mk(3, 3, 4, 0);
      tick();
      chk("postrst_R3", RsData,     16'h0000);
      chk("postrst_R4", RtData,     16'h0000);
      chk("postrst_V",  16'(Valid), 16'h0001);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
